shift_restorer: RTL

SHIFT_RESTORER -- requirements
Module: shift_restorer

---
 rtl/shift_restorer_pkg.sv | 28 ++
 rtl/shift_restorer_counter.sv | 36 +++
 rtl/shift_restorer.sv | 88 ++++++++
 3 files changed

// File: rtl/shift_restorer_pkg.sv
// ============================================================================
// shift_restorer_pkg
// Shared constants for the normalizer / shift-restorer slice: default widths,
// normalizer count constants and the restorer FSM state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_restorer_pkg;

  // Default parameter values of the restorer
  localparam int DEF_N     = 16;
  localparam int DEF_M     = 3;
  localparam int DEF_OUT_W = 32;

  // Normalizer count field: M+1 bits, largest representable shift
  localparam int NORM_CNT_W     = DEF_M + 1;
  localparam int NORM_MAX_SHIFT = (1 << NORM_CNT_W) - 1;

  // Restorer FSM encoding
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/shift_restorer_counter.sv
// ============================================================================
// shift_counter
// Loadable down-counter holding the remaining shift count; zero flags the
// point where the restorer stops shifting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero
);

  // Load has priority over decrement; the FSM never asserts both at once
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (dec) begin
      q <= q - W'(1);
    end
  end

  assign zero = (q == '0);

endmodule

`default_nettype wire

// File: rtl/shift_restorer.sv
// ============================================================================
// shift_restorer
// Restores a normalized operand to its original position by shifting it left
// one bit per cycle by the stored worthless-bit count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_restorer
  import shift_restorer_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     useful_in,
  input  logic [M:0]       num_worthless_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] data_out
);

  logic [STATE_W-1:0] state;
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   useful_ext;
  logic [M:0]         cnt_q;
  logic               cnt_zero;
  logic               accept;
  logic               shift_en;

  // Operands are only taken when idle; a shift happens while count remains
  assign accept   = (state == ST_IDLE) && start;
  assign shift_en = (state == ST_SHIFT) && !cnt_zero;

  // Zero-extend the useful bits into the accumulator width (OUT_W >= N)
  always_comb begin
    useful_ext         = '0;
    useful_ext[N-1:0]  = useful_in;
  end

  // Control FSM: IDLE -> SHIFT until the count is exhausted -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_SHIFT;
        ST_SHIFT: if (cnt_zero) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Shift accumulator; bits leaving the top are dropped, the result is held
  // until the next accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= useful_ext;
    end else if (shift_en) begin
      acc <= acc << 1;
    end
  end

  shift_counter #(
    .W (M + 1)
  ) u_shift_counter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (shift_en),
    .d    (num_worthless_in),
    .q    (cnt_q),
    .zero (cnt_zero)
  );

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign data_out = acc;

endmodule

`default_nettype wire
